// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath widths and load-kind encoding for the MIPS pipeline.
package mips_pkg;
   localparam int WIDTH = 32;
   localparam int REGBITS = 5;
   typedef enum logic [2:0] {
      LD_W  = 3'd0,
      LD_H  = 3'd1,
      LD_HU = 3'd2,
      LD_B  = 3'd3,
      LD_BU = 3'd4
   } ldtype_e;
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the byte/halfword lane of a loaded word, extends it and flags misalignment.
module load_extend #(
   parameter int WIDTH = mips_pkg::WIDTH
) (
   input  logic [2:0]       ldtype,
   input  logic [1:0]       ofs,
   input  logic [WIDTH-1:0] readdata,
   output logic [WIDTH-1:0] data,
   output logic             misaligned
);
   import mips_pkg::*;
   logic [15:0] half;
   logic [7:0]  byte_v;
   always_comb begin
      half = ofs[1] ? readdata[31:16] : readdata[15:0];
      byte_v = ofs[1] ? (ofs[0] ? readdata[31:24] : readdata[23:16])
                      : (ofs[0] ? readdata[15:8] : readdata[7:0]);
      data = readdata;
      misaligned = |ofs;
      // reserved encodings fall through to the word-load default
      case (ldtype_e'(ldtype))
         LD_H: begin
            data = {{(WIDTH-16){half[15]}}, half};
            misaligned = ofs[0];
         end
         LD_HU: begin
            data = {{(WIDTH-16){1'b0}}, half};
            misaligned = ofs[0];
         end
         LD_B: begin
            data = {{(WIDTH-8){byte_v[7]}}, byte_v};
            misaligned = 1'b0;
         end
         LD_BU: begin
            data = {{(WIDTH-8){1'b0}}, byte_v};
            misaligned = 1'b0;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, load extension, register-file write port,
// forwarding tap and retired-instruction counter.
module writeback_stage #(
   parameter int WIDTH   = mips_pkg::WIDTH,
   parameter int REGBITS = mips_pkg::REGBITS,
   parameter int CNTW    = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               valid_m,
   input  logic               regwrite_m,
   input  logic               memtoreg_m,
   input  logic [2:0]         ldtype_m,
   input  logic [WIDTH-1:0]   aluout_m,
   input  logic [WIDTH-1:0]   readdata_m,
   input  logic [REGBITS-1:0] writereg_m,
   input  logic               stall_w,
   input  logic               flush_w,
   output logic               we3,
   output logic [REGBITS-1:0] wa3,
   output logic [WIDTH-1:0]   wd3,
   output logic               fwd_valid,
   output logic [REGBITS-1:0] fwd_reg,
   output logic [WIDTH-1:0]   fwd_data,
   output logic               misalign,
   output logic [CNTW-1:0]    retire_count
);
   import mips_pkg::*;
   logic               valid_q, regwrite_q, memtoreg_q, ld_mis;
   logic [2:0]         ldtype_q;
   logic [WIDTH-1:0]   aluout_q, readdata_q, ld_data;
   logic [REGBITS-1:0] writereg_q;
   logic [CNTW-1:0]    cnt_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n || flush_w) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         ldtype_q   <= '0;
         aluout_q   <= '0;
         readdata_q <= '0;
         writereg_q <= '0;
      end else if (!stall_w) begin
         valid_q    <= valid_m;
         regwrite_q <= regwrite_m;
         memtoreg_q <= memtoreg_m;
         ldtype_q   <= ldtype_m;
         aluout_q   <= aluout_m;
         readdata_q <= readdata_m;
         writereg_q <= writereg_m;
      end
   end
   // an instruction retires when it leaves WB; a stalled one leaves later
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else if (valid_q && !stall_w)
         cnt_q <= cnt_q + 1'b1;
   end
   load_extend #(.WIDTH(WIDTH)) u_ext (
      .ldtype(ldtype_q),
      .ofs(aluout_q[1:0]),
      .readdata(readdata_q),
      .data(ld_data),
      .misaligned(ld_mis)
   );
   always_comb begin
      misalign = valid_q & memtoreg_q & ld_mis;
      wa3 = writereg_q;
      wd3 = memtoreg_q ? ld_data : aluout_q;
      we3 = valid_q & regwrite_q & (|writereg_q) & ~misalign;
      fwd_valid = we3;
      fwd_reg = wa3;
      fwd_data = wd3;
   end
   assign retire_count = cnt_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: vector table, directed stall/flush/reset/wrap sequences and random
// stimulus checked against a behavioural model of the writeback stage.
module tb_writeback_stage;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        valid_m, regwrite_m, memtoreg_m, stall_w, flush_w;
   logic [2:0]  ldtype_m;
   logic [31:0] aluout_m, readdata_m;
   logic [4:0]  writereg_m;
   logic        we3, fwd_valid, misalign;
   logic [4:0]  wa3, fwd_reg;
   logic [31:0] wd3, fwd_data, retire_count;
   logic        w_we3, w_fwd_valid, w_misalign;
   logic [4:0]  w_wa3, w_fwd_reg;
   logic [31:0] w_wd3, w_fwd_data;
   logic [3:0]  w_retire;
   int tests = 0, fails = 0;

   writeback_stage dut (
      .clk(clk), .reset_n(reset_n), .valid_m(valid_m), .regwrite_m(regwrite_m),
      .memtoreg_m(memtoreg_m), .ldtype_m(ldtype_m), .aluout_m(aluout_m),
      .readdata_m(readdata_m), .writereg_m(writereg_m), .stall_w(stall_w), .flush_w(flush_w),
      .we3(we3), .wa3(wa3), .wd3(wd3), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
      .fwd_data(fwd_data), .misalign(misalign), .retire_count(retire_count)
   );

   // narrow counter instance so the wrap-around is reachable in a short run
   writeback_stage #(.CNTW(4)) dut_w (
      .clk(clk), .reset_n(reset_n), .valid_m(valid_m), .regwrite_m(regwrite_m),
      .memtoreg_m(memtoreg_m), .ldtype_m(ldtype_m), .aluout_m(aluout_m),
      .readdata_m(readdata_m), .writereg_m(writereg_m), .stall_w(stall_w), .flush_w(flush_w),
      .we3(w_we3), .wa3(w_wa3), .wd3(w_wd3), .fwd_valid(w_fwd_valid), .fwd_reg(w_fwd_reg),
      .fwd_data(w_fwd_data), .misalign(w_misalign), .retire_count(w_retire)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v, rw, mt;
      logic [2:0]  lt;
      logic [31:0] alu, rd;
      logic [4:0]  wr;
   } inst_t;

   inst_t       m = '0;
   int unsigned cnt_exp = 0;

   // behavioural model: the instruction currently sitting in WB plus a retire tally
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m <= '0;
         cnt_exp <= 0;
      end else begin
         cnt_exp <= cnt_exp + ((m.v && !stall_w) ? 1 : 0);
         m <= flush_w ? '0 : stall_w ? m
            : inst_t'{valid_m, regwrite_m, memtoreg_m, ldtype_m, aluout_m, readdata_m, writereg_m};
      end
   end

   function automatic logic [31:0] ext_load(logic [2:0] lt, logic [1:0] ofs, logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * ofs)) & 32'hFF;
      h = (rd >> (16 * ofs[1])) & 32'hFFFF;
      case (lt)
         3'd1: return h[15] ? (h | 32'hFFFF_0000) : h;
         3'd2: return h;
         3'd3: return b[7] ? (b | 32'hFFFF_FF00) : b;
         3'd4: return b;
         default: return rd;
      endcase
   endfunction

   function automatic logic mis_load(logic [2:0] lt, logic [1:0] ofs);
      case (lt)
         3'd1, 3'd2: return ofs[0];
         3'd3, 3'd4: return 1'b0;
         default: return ofs != 2'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic        emis, ewe;
      logic [31:0] ewd;
      emis = m.v & m.mt & mis_load(m.lt, m.alu[1:0]);
      ewd = m.mt ? ext_load(m.lt, m.alu[1:0], m.rd) : m.alu;
      ewe = m.v & m.rw & (m.wr != 5'd0) & !emis;
      chk({tag, " we3"}, 32'(we3), 32'(ewe));
      chk({tag, " wa3"}, 32'(wa3), 32'(m.wr));
      chk({tag, " wd3"}, wd3, ewd);
      chk({tag, " misalign"}, 32'(misalign), 32'(emis));
      chk({tag, " fwd_valid"}, 32'(fwd_valid), 32'(ewe));
      chk({tag, " fwd_reg"}, 32'(fwd_reg), 32'(m.wr));
      chk({tag, " fwd_data"}, fwd_data, ewd);
      chk({tag, " retire_count"}, retire_count, cnt_exp);
      chk({tag, " retire_count4"}, 32'(w_retire), cnt_exp & 32'hF);
   endtask

   task automatic set_in(input logic v, rw, mt, input logic [2:0] lt,
                         input logic [31:0] alu, rd, input logic [4:0] wr);
      valid_m = v; regwrite_m = rw; memtoreg_m = mt; ldtype_m = lt;
      aluout_m = alu; readdata_m = rd; writereg_m = wr;
   endtask

   typedef struct {
      logic        v, rw, mt;
      logic [2:0]  lt;
      logic [31:0] alu, rd;
      logic [4:0]  wr;
      logic        e_we;
      logic [31:0] e_wd;
      logic        e_mis;
   } vec_t;

   vec_t        tbl[10];
   int unsigned saved;

   initial begin
      stall_w = 1'b0; flush_w = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0);
      // reset held: inputs toggle, nothing must come out
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         set_in(1, 1, $urandom_range(0, 1), 3'($urandom), $urandom, $urandom, 5'($urandom_range(1, 31)));
      end
      @(negedge clk);
      chk("reset we3", 32'(we3), 0);
      chk("reset wd3", wd3, 0);
      chk("reset count", retire_count, 0);
      check_all("reset");
      reset_n = 1'b1;

      tbl[0] = '{1, 1, 0, 0, 32'h0000_1234, 32'h0, 8, 1, 32'h0000_1234, 0};
      tbl[1] = '{1, 1, 1, 3, 32'h0000_0003, 32'h80FF_7F01, 2, 1, 32'hFFFF_FF80, 0};
      tbl[2] = '{1, 1, 1, 4, 32'h0000_0003, 32'h80FF_7F01, 2, 1, 32'h0000_0080, 0};
      tbl[3] = '{1, 1, 1, 1, 32'h0000_0002, 32'h80FF_7F01, 3, 1, 32'hFFFF_80FF, 0};
      tbl[4] = '{1, 1, 1, 2, 32'h0000_0002, 32'h80FF_7F01, 3, 1, 32'h0000_80FF, 0};
      tbl[5] = '{1, 1, 1, 0, 32'h0000_0102, 32'h1122_3344, 5, 0, 32'h1122_3344, 1};
      tbl[6] = '{1, 1, 1, 1, 32'h0000_0001, 32'h80FF_7F01, 6, 0, 32'h0000_7F01, 1};
      tbl[7] = '{1, 1, 0, 0, 32'hDEAD_BEEF, 32'h0, 0, 0, 32'hDEAD_BEEF, 0};
      tbl[8] = '{1, 1, 1, 0, 32'h0000_0100, 32'hCAFE_F00D, 7, 1, 32'hCAFE_F00D, 0};
      tbl[9] = '{1, 1, 1, 7, 32'h0000_0004, 32'h8765_4321, 9, 1, 32'h8765_4321, 0};
      for (int i = 0; i < 10; i++) begin
         set_in(tbl[i].v, tbl[i].rw, tbl[i].mt, tbl[i].lt, tbl[i].alu, tbl[i].rd, tbl[i].wr);
         @(negedge clk);
         chk($sformatf("tbl%0d we3", i), 32'(we3), 32'(tbl[i].e_we));
         chk($sformatf("tbl%0d wd3", i), wd3, tbl[i].e_wd);
         chk($sformatf("tbl%0d misalign", i), 32'(misalign), 32'(tbl[i].e_mis));
         check_all($sformatf("tbl%0d", i));
      end
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("tbl retired", retire_count, 10);

      // stall holds instruction A while new MEM data waits
      set_in(1, 1, 0, 0, 32'hA5A5_0001, 32'h0, 9);
      @(negedge clk);
      check_all("stallA");
      saved = cnt_exp;
      stall_w = 1'b1;
      set_in(1, 1, 0, 0, 32'h1111_2222, 32'h0, 4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall wd3", wd3, 32'hA5A5_0001);
         chk("stall wa3", 32'(wa3), 9);
         chk("stall count", retire_count, saved);
         check_all("stall");
      end
      flush_w = 1'b1;
      @(negedge clk);
      chk("flush we3", 32'(we3), 0);
      chk("flush count", retire_count, saved);
      check_all("flush");
      stall_w = 1'b0; flush_w = 1'b0;

      // async reset asserted between edges clears outputs immediately
      set_in(1, 1, 0, 0, 32'h0000_0055, 32'h0, 12);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async we3", 32'(we3), 0);
      chk("async wd3", wd3, 0);
      chk("async count", retire_count, 0);
      check_all("async");
      @(negedge clk);
      reset_n = 1'b1;

      // 16 retires wrap the 4-bit counter to zero
      for (int i = 0; i < 16; i++) begin
         set_in(1, 0, 0, 0, 32'(i), 32'h0, 5'(i));
         @(negedge clk);
      end
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("wrap count4", 32'(w_retire), 0);
      chk("wrap count32", retire_count, 16);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            reset_n = 1'b0;
            #1 check_all("rand reset");
            reset_n = 1'b1;
         end
         stall_w = ($urandom_range(0, 5) == 0);
         flush_w = ($urandom_range(0, 7) == 0);
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                3'($urandom), $urandom, $urandom,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
         @(negedge clk);
         check_all("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
